key_event_decoder: RTL
======================

# key_event_decoder

Classifies debounced key activity into short-press, long-press, double-click and auto-repeat events. It sits directly downstream of the key debounce filter and consumes that filter's `key_flag`/`key_state` pair. It emits single-cycle command pulses to the RAM control logic, which uses them for address step, write and read triggering.

## Interface
- `LONG_CNT`, default 25_000_000: hold time in clocks that qualifies a long press (500 ms at 50 MHz).
- `DBL_CNT`, default 15_000_000: window in clocks, after the first release, for a second press (300 ms).
- `REPEAT_CNT`, default 5_000_000: auto-repeat period in clocks while held (100 ms).
- `CNT_W`, default 25: counter width; must satisfy 2^CNT_W > max(LONG_CNT, DBL_CNT, REPEAT_CNT).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset; one clock, synchronous and active-low.
- `key_flag`  in  1  one-cycle strobe from the debounce filter marking a debounced edge.
- `key_state`  in  1  debounced level; 0 = pressed, 1 = released. Sampled only when `key_flag` = 1.
- `short_press`  out  1  one-cycle pulse for a single short press.
- `long_press`  out  1  one-cycle pulse when the hold time reaches `LONG_CNT`.
- `double_click`  out  1  one-cycle pulse on the second release of a double click.
- `repeat_pulse`  out  1  one-cycle periodic pulse while held after a long press.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Input events:
  - press = `key_flag` & !`key_state`.
  - release = `key_flag` & `key_state`.
  - Any event not listed for the current state is ignored.
- Counter `cnt` (`CNT_W` bits) clears to 0 on every state change. It increments by 1 each clock in PRESS1, WAIT2 and HELD, and holds at 0 in IDLE and PRESS2.
- One-hot states and transitions:
  - IDLE: press → PRESS1.
  - PRESS1: release → WAIT2. Otherwise, `cnt` == `LONG_CNT`-1 → HELD and pulse `long_press`.
  - WAIT2: press → PRESS2. Otherwise, `cnt` == `DBL_CNT`-1 → IDLE and pulse `short_press`.
  - PRESS2: release → IDLE and pulse `double_click`. No long-press detection in this state.
  - HELD: release → IDLE with no pulse. `cnt` == `REPEAT_CNT`-1 → pulse `repeat_pulse` and clear `cnt`; state stays HELD.
  - Undefined encoding → IDLE, `cnt` = 0, all pulses 0.
- Simultaneous events:
  - Release in the same cycle as the PRESS1 terminal count: release wins, giving WAIT2 with no `long_press`.
  - Press in the same cycle as the WAIT2 terminal count: press wins, giving PRESS2 with no `short_press`.
  - Release in the same cycle as a HELD repeat terminal count: release wins, giving IDLE with no `repeat_pulse`.
- All outputs are registered. At most one pulse output is high in any cycle.

## Timing
- Reset (`rst_n` low at a rising edge):
  - state = IDLE, `cnt` = 0.
  - `short_press`, `long_press`, `double_click`, `repeat_pulse` and `busy` are all 0.
  - Any in-progress classification is discarded, with no pulse emitted. The first event after reset must be a press.
- Latency is counted in edges from the edge that samples the triggering event, edge E:
  - `double_click` is high in the cycle following E.
  - `short_press` follows `DBL_CNT` edges after the edge that sampled the first release.
  - `long_press` follows `LONG_CNT` edges after the edge that sampled the first press.
  - The first `repeat_pulse` follows `REPEAT_CNT` edges after the `long_press` edge; subsequent pulses repeat every `REPEAT_CNT` edges.
- `busy` rises the cycle after the first press is sampled. It falls in the same cycle the final pulse asserts, or the cycle after a HELD release.
- Back-to-back `key_flag` strobes on consecutive clocks are each processed in order.

## Configuration
- `KEY_REPEAT_EN` defined: the HELD repeat counter and `repeat_pulse` generation are compiled in, as described above.
- `KEY_REPEAT_EN` undefined:
  - `repeat_pulse` is tied to constant 0.
  - HELD does not count: `cnt` holds at 0 and only release leaves HELD.
  - `REPEAT_CNT` is unused.

## Test plan
Bench parameters: `LONG_CNT`=20, `DBL_CNT`=10, `REPEAT_CNT`=4, `CNT_W`=8.
- Short press: press, release 5 clocks later, then idle → one `short_press` 10 edges after the release edge; no other pulses; `busy` returns to 0.
- Double click: press, release @+5, press @+3, release @+4 → one `double_click` the cycle after the second release; `short_press` stays 0.
- Long press with repeat (`KEY_REPEAT_EN` defined): press, hold 35 clocks → `long_press` at edge +20, `repeat_pulse` at +24/+28/+32. Release → IDLE with no further pulses. With the macro undefined → `long_press` only.
- Race at the boundary: release exactly at PRESS1 `cnt`=19 → no `long_press`, enter WAIT2. Press exactly at WAIT2 `cnt`=9 → PRESS2, no `short_press`.
- Reset mid-operation: press, then drive `rst_n` low at +12 for 1 clock → all outputs 0, `busy`=0. A following release is ignored; the next press/release starts clean.
- Stray events: release strobe while IDLE, and press strobe while HELD → ignored; state and outputs unchanged.

Source files
------------

// File: rtl/key_event_decoder.sv
// Classifies debounced key strobes into short-press, long-press, double-click and auto-repeat pulses.
// Optional feature macro: KEY_REPEAT_EN (periodic repeat_pulse while the key is held after a long press).
module key_event_decoder #(
    parameter int unsigned LONG_CNT   = 25_000_000,
    parameter int unsigned DBL_CNT    = 15_000_000,
    parameter int unsigned REPEAT_CNT = 5_000_000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_flag,
    input  logic key_state,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CNT - 1);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        PRESS1 = 5'b00010,
        WAIT2  = 5'b00100,
        PRESS2 = 5'b01000,
        HELD   = 5'b10000
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_short;
    logic             r_long;
    logic             r_double;
    logic             r_repeat;
    logic             r_busy;

    logic w_press;
    logic w_release;

    // Debounced edge qualified by the level it settled to.
    assign w_press   = key_flag & ~key_state;
    assign w_release = key_flag &  key_state;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);
`else
    logic w_unused_repeat_cnt;
    assign w_unused_repeat_cnt = (REPEAT_CNT == 0);
`endif

    // Classification FSM; the leaving event always outranks a terminal count in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_repeat <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_repeat <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_press) begin
                        r_state <= PRESS1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                PRESS1: begin
                    r_busy <= 1'b1;
                    if (w_release) begin
                        r_state <= WAIT2;
                        r_cnt   <= '0;
                    end else if (r_cnt == LONG_TC) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        r_long  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                WAIT2: begin
                    if (w_press) begin
                        r_state <= PRESS2;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else if (r_cnt == DBL_TC) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_short <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                PRESS2: begin
                    r_cnt <= '0;
                    if (w_release) begin
                        r_state  <= IDLE;
                        r_double <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_busy   <= 1'b1;
                    end
                end
                HELD: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_busy  <= 1'b1;
`ifdef KEY_REPEAT_EN
                        if (r_cnt == REPEAT_TC) begin
                            r_cnt    <= '0;
                            r_repeat <= 1'b1;
                        end else begin
                            r_cnt    <= r_cnt + CNT_W'(1);
                        end
`else
                        r_cnt   <= '0;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign double_click = r_double;
    assign busy         = r_busy;
`ifdef KEY_REPEAT_EN
    assign repeat_pulse = r_repeat;
`else
    assign repeat_pulse = 1'b0;

    logic w_unused_repeat_reg;
    assign w_unused_repeat_reg = r_repeat;
`endif

endmodule
